// File: rtl/spmv_operand_join_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spmv_operand_join_pkg
// Brief    : Shared widths and a log2 helper for the SpMV operand join block.
// Revision : 1.0
// ============================================================================
package spmv_operand_join_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int COL_WIDTH  = 32;
    localparam int ROW_WIDTH  = 32;

    // Ceiling log2 for elaboration-time sizing of pointers and counters.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spmv_operand_join_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spmv_show_ahead_fifo
// Brief    : Power-of-two show-ahead FIFO with registered occupancy count.
// Revision : 1.0
// ============================================================================
module spmv_show_ahead_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          push,
    input  logic [WIDTH-1:0]                              din,
    input  logic                                          pop,
    output logic [WIDTH-1:0]                              q,
    output logic                                          empty,
    output logic                                          full,
    output logic [spmv_operand_join_pkg::clog2(DEPTH):0]  count
);
    import spmv_operand_join_pkg::*;

    localparam int            AW      = clog2(DEPTH);
    localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != c_DEPTH) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign q     = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == c_DEPTH);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/spmv_operand_join.sv
`default_nettype none
// ============================================================================
// Module   : spmv_operand_join
// Brief    : Joins x-vector and matrix-value streams into multiplier operands.
// Revision : 1.0
// ============================================================================
module spmv_operand_join #(
    parameter int DATA_WIDTH     = spmv_operand_join_pkg::DATA_WIDTH,
    parameter int X_FIFO_DEPTH   = 32,
    parameter int VAL_FIFO_DEPTH = 32,
    parameter int STALL_SLACK    = 5,
    parameter int VAL_AF_SLACK   = 4,
    parameter int ROW_WIDTH      = spmv_operand_join_pkg::ROW_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_x,
    input  logic [DATA_WIDTH-1:0] x_val,
    output logic                  stall,
    input  logic                  push_val,
    input  logic [DATA_WIDTH-1:0] val,
    input  logic                  val_last,
    output logic                  val_almost_full,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic                  out_last,
    output logic [ROW_WIDTH-1:0]  out_row,
    output logic                  overflow_err
);
    import spmv_operand_join_pkg::*;

    localparam int               XCW          = clog2(X_FIFO_DEPTH) + 1;
    localparam int               VCW          = clog2(VAL_FIFO_DEPTH) + 1;
    localparam logic [XCW-1:0]   c_X_STALL_TH = XCW'(X_FIFO_DEPTH - STALL_SLACK);
    localparam logic [VCW-1:0]   c_V_AF_TH    = VCW'(VAL_FIFO_DEPTH - VAL_AF_SLACK);

    logic [DATA_WIDTH-1:0] w_x_q;
    logic                  w_x_empty;
    logic                  w_x_full;
    logic [XCW-1:0]        w_x_count;
    logic [DATA_WIDTH:0]   w_v_q;
    logic                  w_v_empty;
    logic                  w_v_full;
    logic [VCW-1:0]        w_v_count;
    logic                  w_load;
    logic                  w_row_adv;
    logic [ROW_WIDTH-1:0]  w_row_next;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_a;
    logic [DATA_WIDTH-1:0] r_out_b;
    logic                  r_out_last;
    logic [ROW_WIDTH-1:0]  r_out_row;
    logic [ROW_WIDTH-1:0]  r_row_cnt;
    logic                  r_stall;
    logic                  r_val_af;
    logic                  r_overflow;

    spmv_show_ahead_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (X_FIFO_DEPTH)
    ) u_x_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_x),
        .din   (x_val),
        .pop   (w_load),
        .q     (w_x_q),
        .empty (w_x_empty),
        .full  (w_x_full),
        .count (w_x_count)
    );

    spmv_show_ahead_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (VAL_FIFO_DEPTH)
    ) u_val_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_val),
        .din   ({val_last, val}),
        .pop   (w_load),
        .q     (w_v_q),
        .empty (w_v_empty),
        .full  (w_v_full),
        .count (w_v_count)
    );

    assign w_load     = !w_x_empty && !w_v_empty && (!r_out_valid || out_ready);
    assign w_row_adv  = r_out_valid && out_ready && r_out_last;
    // A pair loaded in the cycle a row closes already belongs to the next row.
    assign w_row_next = r_row_cnt + {{(ROW_WIDTH-1){1'b0}}, w_row_adv};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_last  <= 1'b0;
            r_out_row   <= '0;
            r_row_cnt   <= '0;
            r_stall     <= 1'b0;
            r_val_af    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_row_cnt <= w_row_next;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_a     <= w_v_q[DATA_WIDTH-1:0];
                r_out_last  <= w_v_q[DATA_WIDTH];
                r_out_b     <= w_x_q;
                r_out_row   <= w_row_next;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_stall  <= (w_x_count >= c_X_STALL_TH);
            r_val_af <= (w_v_count >= c_V_AF_TH);
            if ((push_x && w_x_full && !w_load) || (push_val && w_v_full && !w_load)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign stall           = r_stall;
    assign val_almost_full = r_val_af;
    assign out_valid       = r_out_valid;
    assign out_a           = r_out_a;
    assign out_b           = r_out_b;
    assign out_last        = r_out_last;
    assign out_row         = r_out_row;
    assign overflow_err    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_spmv_operand_join.sv
`default_nettype none
// ============================================================================
// Module   : tb_spmv_operand_join
// Brief    : Directed plus randomized self-checking bench for spmv_operand_join.
// Revision : 1.0
// ============================================================================
module tb_spmv_operand_join;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_x;
    logic [63:0] x_val;
    logic        push_val;
    logic [63:0] val;
    logic        val_last;
    logic        out_ready;

    logic        stall, val_af, out_valid, out_last, ovf;
    logic [63:0] out_a, out_b;
    logic [31:0] out_row;
    logic        stall4, val_af4, out_valid4, out_last4, ovf4;
    logic [63:0] out_a4, out_b4;
    logic [3:0]  out_row4;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        last;
        int unsigned row;
    } pair_t;

    logic [63:0] qx[$];
    logic [64:0] qv[$];
    pair_t       exp_q[$];
    int unsigned model_row = 0;
    bit          model_accept_x = 1'b1;

    always #5 clk = ~clk;

    spmv_operand_join dut (
        .clk(clk), .rst(rst), .push_x(push_x), .x_val(x_val), .stall(stall),
        .push_val(push_val), .val(val), .val_last(val_last),
        .val_almost_full(val_af), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_last(out_last), .out_row(out_row),
        .overflow_err(ovf)
    );

    spmv_operand_join #(.ROW_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .push_x(push_x), .x_val(x_val), .stall(stall4),
        .push_val(push_val), .val(val), .val_last(val_last),
        .val_almost_full(val_af4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_a(out_a4), .out_b(out_b4), .out_last(out_last4), .out_row(out_row4),
        .overflow_err(ovf4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference: the n-th x joins the n-th value; rows advance after each last.
    function automatic void model_pair();
        while (qx.size() > 0 && qv.size() > 0) begin
            pair_t       p;
            logic [64:0] v;
            v      = qv.pop_front();
            p.a    = v[63:0];
            p.last = v[64];
            p.b    = qx.pop_front();
            p.row  = model_row;
            if (p.last) model_row++;
            exp_q.push_back(p);
        end
    endfunction

    // Scores the visible pair, records this cycle's pushes, then advances a clock.
    task automatic step();
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pair", {63'd0, out_valid}, 64'd0);
            end else begin
                pair_t p;
                p = exp_q[0];
                chk("out_a",    out_a, p.a);
                chk("out_b",    out_b, p.b);
                chk("out_last", {63'd0, out_last}, {63'd0, p.last});
                chk("out_row",  {32'd0, out_row}, {32'd0, p.row});
                chk("out_row4", {60'd0, out_row4}, {60'd0, p.row[3:0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (push_x && model_accept_x) qx.push_back(x_val);
        if (push_val) qv.push_back({val_last, val});
        model_pair();
        @(posedge clk);
        #1;
        push_x   = 1'b0;
        push_val = 1'b0;
        x_val    = rnd64();
        val      = rnd64();
        val_last = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
        chk("drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int pushes;
        rst = 1'b1; push_x = 0; push_val = 0; x_val = 0; val = 0; val_last = 0; out_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_stall",     {63'd0, stall}, 64'd0);
        chk("rst_val_af",    {63'd0, val_af}, 64'd0);
        chk("rst_out_a",     out_a, 64'd0);
        chk("rst_out_b",     out_b, 64'd0);
        chk("rst_out_last",  {63'd0, out_last}, 64'd0);
        chk("rst_out_row",   {32'd0, out_row}, 64'd0);
        chk("rst_overflow",  {63'd0, ovf}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic join and two-cycle latency
        out_ready = 1'b1;
        push_x = 1; x_val = 64'h3FF0000000000000;
        push_val = 1; val = 64'h4000000000000000; val_last = 1;
        step();
        chk("lat_n1_valid", {63'd0, out_valid}, 64'd0);
        step();
        chk("lat_n2_valid", {63'd0, out_valid}, 64'd1);
        chk("basic_out_a", out_a, 64'h4000000000000000);
        chk("basic_out_b", out_b, 64'h3FF0000000000000);
        chk("basic_row", {32'd0, out_row}, 64'd0);
        push_x = 1; push_val = 1; val_last = 1'($urandom);
        step();
        step();
        chk("basic_row_next", {32'd0, out_row}, 64'd1);
        drain(4);

        // Imbalance: x only, then values back-to-back
        for (int i = 0; i < 10; i++) begin
            push_x = 1;
            step();
            chk("imb_no_valid", {63'd0, out_valid}, 64'd0);
        end
        chk("imb_x_count", 64'(dut.w_x_count), 64'd10);
        for (int i = 0; i < 10; i++) begin
            push_val = 1; val_last = 1'($urandom);
            step();
            chk("imb_valid", {63'd0, out_valid}, (i >= 1) ? 64'd1 : 64'd0);
        end
        step();
        chk("imb_last_valid", {63'd0, out_valid}, 64'd1);
        drain(4);

        // Backpressure on the x side with a held output pair
        push_x = 1; push_val = 1;
        step();
        step();
        out_ready = 1'b0;
        chk("bp_held_valid", {63'd0, out_valid}, 64'd1);
        pushes = 0;
        for (int i = 0; i < 40; i++) begin
            push_x = 1;
            step();
            pushes++;
            chk("bp_stall_track", {63'd0, stall}, (pushes - 1 >= 27) ? 64'd1 : 64'd0);
            if (stall === 1'b1) break;
        end
        chk("bp_stall_at", 64'(pushes), 64'd28);
        for (int i = 0; i < 3; i++) begin
            push_x = 1;
            step();
            chk("bp_stall_hold", {63'd0, stall}, 64'd1);
        end
        chk("bp_x_count", 64'(dut.w_x_count), 64'(pushes + 3));
        chk("bp_no_overflow", {63'd0, ovf}, 64'd0);

        // Overflow: fill to 32, then one dropped push
        while (dut.w_x_count < 6'd32 && pushes < 40) begin
            push_x = 1; step(); pushes++;
        end
        chk("ovf_full_count", 64'(dut.w_x_count), 64'd32);
        chk("ovf_before", {63'd0, ovf}, 64'd0);
        model_accept_x = 1'b0;
        push_x = 1;
        step();
        model_accept_x = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("ovf_sticky", {63'd0, ovf}, 64'd1);
            step();
        end

        // Value almost-full threshold while the output stage is stalled
        for (int k = 1; k <= 28; k++) begin
            push_val = 1;
            step();
            chk("vaf_track", {63'd0, val_af}, (k - 1 >= 28) ? 64'd1 : 64'd0);
        end
        step();
        chk("vaf_set", {63'd0, val_af}, 64'd1);

        // Asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_stall", {63'd0, stall}, 64'd0);
        chk("arst_ovf",   {63'd0, ovf}, 64'd0);
        qx.delete(); qv.delete(); exp_q.delete(); model_row = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        push_x = 1; push_val = 1; val_last = 1;
        step();
        step();
        chk("arst_pair_valid", {63'd0, out_valid}, 64'd1);
        chk("arst_pair_row", {32'd0, out_row}, 64'd0);
        drain(3);

        // Row wrap on the 4-bit instance: 17 last-flagged pairs
        for (int i = 0; i < 17; i++) begin
            push_x = 1; push_val = 1; val_last = 1;
            step();
        end
        chk("wrap_row4", {60'd0, out_row4}, 64'd0);
        chk("wrap_row32", {32'd0, out_row}, 64'd16);
        drain(4);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            push_x    = ($urandom_range(0, 1) == 1) && (qx.size() + exp_q.size() < 20);
            push_val  = ($urandom_range(0, 1) == 1) && (qv.size() + exp_q.size() < 20);
            val_last  = ($urandom_range(0, 3) == 0);
            step();
        end
        chk("rand_no_overflow", {63'd0, ovf}, 64'd0);
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
